// File: rtl/mem_port_ctrl_pkg.sv
// rtl/mem_port_ctrl_pkg.sv - shared types and defaults for the memory port controller
package mem_port_ctrl_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int WBUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STORE
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [XLEN_DEF-1:0]     addr;
        logic [XLEN_DEF-1:0]     wdata;
        logic [XLEN_DEF/8-1:0]   be;
    } bus_cmd_t;

    // Only whole words travel on the bus.
    function automatic logic [XLEN_DEF-1:0] word_align(input logic [XLEN_DEF-1:0] a);
        return {a[XLEN_DEF-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// rtl/mem_port_ctrl_if.sv - pipeline request/response and external bus signal bundle
interface mem_port_if
    import mem_port_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic              f_req;
    logic [XLEN-1:0]   f_addr;
    logic [XLEN-1:0]   f_rdata;
    logic              mem_valid_f;

    logic              m_req;
    logic              m_we;
    logic [XLEN-1:0]   m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [XLEN/8-1:0] m_be;
    logic [XLEN-1:0]   m_rdata;
    logic              mem_valid_m;
    logic              wbuf_empty;

    logic              bus_req;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN/8-1:0] bus_be;
    logic              bus_ack;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        input  f_req, f_addr, m_req, m_we, m_addr, m_wdata, m_be, bus_ack, bus_rdata,
        output f_rdata, mem_valid_f, m_rdata, mem_valid_m, wbuf_empty,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        output f_req, f_addr, m_req, m_we, m_addr, m_wdata, m_be, bus_ack, bus_rdata,
        input  f_rdata, mem_valid_f, m_rdata, mem_valid_m, wbuf_empty,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

endinterface

// File: rtl/mem_port_ctrl_store_buffer.sv
// rtl/mem_port_ctrl_store_buffer.sv - posted-store FIFO with registered full/empty flags
module store_buffer
    import mem_port_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = WBUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [XLEN-1:0]   push_addr_i,
    input  logic [XLEN-1:0]   push_wdata_i,
    input  logic [XLEN/8-1:0] push_be_i,
    input  logic              pop_i,
    output logic [XLEN-1:0]   head_addr_o,
    output logic [XLEN-1:0]   head_wdata_o,
    output logic [XLEN/8-1:0] head_be_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] be;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, empty_q;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags are registered from the next count so they line up with the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= '{addr: push_addr_i, wdata: push_wdata_i, be: push_be_i};
        end
    end

    assign head_addr_o  = mem_q[rd_ptr_q].addr;
    assign head_wdata_o = mem_q[rd_ptr_q].wdata;
    assign head_be_o    = mem_q[rd_ptr_q].be;
    assign full_o       = full_q;
    assign empty_o      = empty_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - single-bus fetch/load/store responder with posted write buffer
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mem_port_if.master mp
);
    state_t          state_q, state_d;
    bus_cmd_t        cmd_q, cmd_d;
    logic            bus_req_q, bus_req_d;
    logic [XLEN-1:0] f_rdata_q, f_rdata_d;
    logic [XLEN-1:0] m_rdata_q, m_rdata_d;
    logic [XLEN-1:0] f_lat_q, f_lat_d;
    logic            valid_f_q, valid_f_d;
    logic            valid_m_q, valid_m_d;

    logic              sb_push, sb_pop, sb_full, sb_empty;
    logic [XLEN-1:0]   sb_addr, sb_wdata;
    logic [XLEN/8-1:0] sb_be;

    assign sb_push = mp.m_req && mp.m_we && !sb_full;

    store_buffer #(
        .XLEN  (XLEN),
        .DEPTH (WBUF_DEPTH)
    ) u_store_buffer (
        .clk          (clk),
        .rst          (rst),
        .push_i       (sb_push),
        .push_addr_i  (mp.m_addr),
        .push_wdata_i (mp.m_wdata),
        .push_be_i    (mp.m_be),
        .pop_i        (sb_pop),
        .head_addr_o  (sb_addr),
        .head_wdata_o (sb_wdata),
        .head_be_o    (sb_be),
        .full_o       (sb_full),
        .empty_o      (sb_empty)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        bus_req_d = bus_req_q;
        f_rdata_d = f_rdata_q;
        m_rdata_d = m_rdata_q;
        f_lat_d   = f_lat_q;
        valid_f_d = 1'b0;
        valid_m_d = 1'b0;
        sb_pop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Draining stores first keeps loads ordered behind them without forwarding.
                if (!sb_empty) begin
                    state_d     = S_STORE;
                    bus_req_d   = 1'b1;
                    cmd_d.we    = 1'b1;
                    cmd_d.addr  = word_align(sb_addr);
                    cmd_d.wdata = sb_wdata;
                    cmd_d.be    = sb_be;
                end else if (mp.m_req && !mp.m_we) begin
                    state_d     = S_LOAD;
                    bus_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = word_align(mp.m_addr);
                    cmd_d.wdata = '0;
                    cmd_d.be    = '1;
                end else if (mp.f_req) begin
                    state_d     = S_FETCH;
                    bus_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = word_align(mp.f_addr);
                    cmd_d.wdata = '0;
                    cmd_d.be    = '1;
                    f_lat_d     = mp.f_addr;
                end
            end
            S_FETCH: begin
                if (mp.bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    // A redirected fetch drops the stale word and reissues from IDLE.
                    if (mp.f_addr == f_lat_q) begin
                        valid_f_d = 1'b1;
                        f_rdata_d = mp.bus_rdata;
                    end
                end
            end
            S_LOAD: begin
                if (mp.bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    valid_m_d = 1'b1;
                    m_rdata_d = mp.bus_rdata;
                end
            end
            S_STORE: begin
                if (mp.bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    sb_pop    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            bus_req_q <= 1'b0;
            f_rdata_q <= '0;
            m_rdata_q <= '0;
            f_lat_q   <= '0;
            valid_f_q <= 1'b0;
            valid_m_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            bus_req_q <= bus_req_d;
            f_rdata_q <= f_rdata_d;
            m_rdata_q <= m_rdata_d;
            f_lat_q   <= f_lat_d;
            valid_f_q <= valid_f_d;
            valid_m_q <= valid_m_d;
        end
    end

    assign mp.bus_req     = bus_req_q;
    assign mp.bus_we      = cmd_q.we;
    assign mp.bus_addr    = cmd_q.addr;
    assign mp.bus_wdata   = cmd_q.wdata;
    assign mp.bus_be      = cmd_q.be;
    assign mp.f_rdata     = f_rdata_q;
    assign mp.m_rdata     = m_rdata_q;
    assign mp.mem_valid_f = valid_f_q;
    assign mp.mem_valid_m = valid_m_q | sb_push;
    assign mp.wbuf_empty  = sb_empty;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed self-checking bench for mem_port_ctrl
module tb_mem_port_ctrl;
    import mem_port_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_if #(.XLEN(32)) mif ();

    mem_port_ctrl #(.XLEN(32), .WBUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .mp  (mif.master)
    );

    int checks = 0;
    int errors = 0;

    // Bus slave: ack after ack_wait wait states, word memory of 1024 entries.
    logic [31:0] mem [1024];
    int   ack_wait = 0;
    int   wcnt     = 0;
    logic preload  = 1'b1;

    assign mif.bus_ack   = mif.bus_req && (wcnt == ack_wait);
    assign mif.bus_rdata = mem[mif.bus_addr[11:2]];

    always @(posedge clk) begin
        if (mif.bus_req && !mif.bus_ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[64]  <= 32'h0000_0013;
            mem[192] <= 32'h0050_0093;
            mem[16]  <= 32'hCAFE_F00D;
        end else if (mif.bus_ack && mif.bus_we) begin
            for (int b = 0; b < 4; b++)
                if (mif.bus_be[b]) mem[mif.bus_addr[11:2]][8*b +: 8] <= mif.bus_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int which, input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((which == 0 && mif.mem_valid_f) || (which == 1 && mif.wbuf_empty)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_req"},   mif.bus_req,     32'h0);
        chk({tag, "_bus_we"},    mif.bus_we,      32'h0);
        chk({tag, "_bus_addr"},  mif.bus_addr,    32'h0);
        chk({tag, "_bus_wdata"}, mif.bus_wdata,   32'h0);
        chk({tag, "_bus_be"},    mif.bus_be,      32'h0);
        chk({tag, "_valid_f"},   mif.mem_valid_f, 32'h0);
        chk({tag, "_valid_m"},   mif.mem_valid_m, 32'h0);
        chk({tag, "_f_rdata"},   mif.f_rdata,     32'h0);
        chk({tag, "_m_rdata"},   mif.m_rdata,     32'h0);
        chk({tag, "_wbuf_empty"}, mif.wbuf_empty, 32'h1);
    endtask

    initial begin
        logic ok;
        logic saw300;
        int   hold;

        mif.f_req = 1'b0; mif.f_addr = '0;
        mif.m_req = 1'b0; mif.m_we = 1'b0; mif.m_addr = '0; mif.m_wdata = '0; mif.m_be = '0;

        repeat (2) @(negedge clk);
        preload = 1'b0;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Fetch 0x100 on a zero-wait bus.
        mif.f_req = 1'b1; mif.f_addr = 32'h100;
        @(negedge clk);
        chk("fetch_bus_req",  mif.bus_req,     32'h1);
        chk("fetch_bus_addr", mif.bus_addr,    32'h100);
        chk("fetch_bus_we",   mif.bus_we,      32'h0);
        chk("fetch_bus_be",   mif.bus_be,      32'hF);
        chk("fetch_no_early", mif.mem_valid_f, 32'h0);
        @(negedge clk);
        chk("fetch_valid",    mif.mem_valid_f, 32'h1);
        chk("fetch_rdata",    mif.f_rdata,     32'h13);
        mif.f_req = 1'b0;
        @(negedge clk);
        chk("fetch_pulse_end", mif.mem_valid_f, 32'h0);
        chk("fetch_req_drop",  mif.bus_req,     32'h0);
        chk("fetch_rdata_hold", mif.f_rdata,    32'h13);

        // Store then load to the same address; the load waits for the drain.
        mif.m_req = 1'b1; mif.m_we = 1'b1; mif.m_addr = 32'h200;
        mif.m_wdata = 32'hDEAD_BEEF; mif.m_be = 4'hF;
        #1;
        chk("st_valid_comb", mif.mem_valid_m, 32'h1);
        chk("st_empty_before", mif.wbuf_empty, 32'h1);
        @(negedge clk);
        chk("st_empty_after", mif.wbuf_empty, 32'h0);
        mif.m_we = 1'b0;
        #1;
        chk("ld_not_yet", mif.mem_valid_m, 32'h0);
        @(negedge clk);
        chk("st_bus_req",   mif.bus_req,   32'h1);
        chk("st_bus_we",    mif.bus_we,    32'h1);
        chk("st_bus_addr",  mif.bus_addr,  32'h200);
        chk("st_bus_wdata", mif.bus_wdata, 32'hDEAD_BEEF);
        chk("st_bus_be",    mif.bus_be,    32'hF);
        chk("ld_wait_drain", mif.mem_valid_m, 32'h0);
        @(negedge clk);
        chk("st_drained",   mif.wbuf_empty, 32'h1);
        chk("st_req_drop",  mif.bus_req,    32'h0);
        @(negedge clk);
        chk("ld_bus_req",   mif.bus_req,   32'h1);
        chk("ld_bus_we",    mif.bus_we,    32'h0);
        chk("ld_bus_addr",  mif.bus_addr,  32'h200);
        @(negedge clk);
        chk("ld_valid",     mif.mem_valid_m, 32'h1);
        chk("ld_rdata",     mif.m_rdata,     32'hDEAD_BEEF);
        mif.m_req = 1'b0;
        @(negedge clk);
        chk("ld_pulse_end", mif.mem_valid_m, 32'h0);

        // Three stores into a depth-2 buffer with a slow bus.
        ack_wait = 4;
        mif.m_req = 1'b1; mif.m_we = 1'b1; mif.m_be = 4'hF;
        mif.m_addr = 32'h10; mif.m_wdata = 32'h1111_1111;
        #1;
        chk("bp_st0_acc", mif.mem_valid_m, 32'h1);
        @(negedge clk);
        mif.m_addr = 32'h14; mif.m_wdata = 32'h2222_2222;
        #1;
        chk("bp_st1_acc", mif.mem_valid_m, 32'h1);
        @(negedge clk);
        mif.m_addr = 32'h18; mif.m_wdata = 32'h3333_3333;
        #1;
        chk("bp_st2_held", mif.mem_valid_m, 32'h0);
        chk("bp_drain_req", mif.bus_req,    32'h1);
        hold = 1;
        ok   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mif.mem_valid_m) begin
                ok = 1'b1;
                break;
            end
            hold++;
        end
        chk("bp_st2_accepted", ok, 32'h1);
        chk("bp_hold_cycles", hold, 32'd5);
        @(negedge clk);
        mif.m_req = 1'b0;
        wait_for(1, 60, ok);
        chk("bp_drain_done", ok, 32'h1);
        @(negedge clk);
        chk("bp_mem0", mem[4], 32'h1111_1111);
        chk("bp_mem1", mem[5], 32'h2222_2222);
        chk("bp_mem2", mem[6], 32'h3333_3333);

        // Fetch redirected while in flight.
        ack_wait = 3;
        mif.f_req = 1'b1; mif.f_addr = 32'h100;
        @(negedge clk);
        chk("rd_first_addr", mif.bus_addr, 32'h100);
        chk("rd_first_req",  mif.bus_req,  32'h1);
        mif.f_addr = 32'h300;
        saw300 = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mif.bus_req && mif.bus_addr == 32'h300) saw300 = 1'b1;
            if (mif.mem_valid_f) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_pulse_seen", ok,          32'h1);
        chk("rd_rdata",      mif.f_rdata, 32'h0050_0093);
        chk("rd_reissued",   saw300,      32'h1);
        mif.f_req = 1'b0;
        @(negedge clk);
        chk("rd_pulse_end", mif.mem_valid_f, 32'h0);

        // Fetch and load in the same IDLE cycle.
        ack_wait = 0;
        mif.m_req = 1'b1; mif.m_we = 1'b0; mif.m_addr = 32'h40;
        mif.f_req = 1'b1; mif.f_addr = 32'h100;
        @(negedge clk);
        chk("arb_load_first", mif.bus_addr, 32'h40);
        chk("arb_load_we",    mif.bus_we,   32'h0);
        @(negedge clk);
        chk("arb_ld_valid",  mif.mem_valid_m, 32'h1);
        chk("arb_ld_rdata",  mif.m_rdata,     32'hCAFE_F00D);
        chk("arb_f_waiting", mif.mem_valid_f, 32'h0);
        mif.m_req = 1'b0;
        @(negedge clk);
        chk("arb_fetch_addr", mif.bus_addr, 32'h100);
        chk("arb_fetch_req",  mif.bus_req,  32'h1);
        @(negedge clk);
        chk("arb_f_valid", mif.mem_valid_f, 32'h1);
        chk("arb_f_rdata", mif.f_rdata,     32'h13);
        mif.f_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset with a store in flight and two buffered.
        ack_wait = 20;
        mif.m_req = 1'b1; mif.m_we = 1'b1; mif.m_be = 4'hF;
        mif.m_addr = 32'h80; mif.m_wdata = 32'hAAAA_5555;
        #1;
        chk("rst_st0_acc", mif.mem_valid_m, 32'h1);
        @(negedge clk);
        mif.m_addr = 32'h84; mif.m_wdata = 32'h5555_AAAA;
        #1;
        chk("rst_st1_acc", mif.mem_valid_m, 32'h1);
        @(negedge clk);
        mif.m_req = 1'b0;
        chk("rst_busy_req",   mif.bus_req,    32'h1);
        chk("rst_busy_empty", mif.wbuf_empty, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle",  mif.bus_req,    32'h0);
        chk("post_rst_empty", mif.wbuf_empty, 32'h1);
        chk("post_rst_nowr",  mem[32],        32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory-side responder for the pipeline's stall protocol. It owns the single external memory bus, serves instruction fetches and data loads/stores, and produces `mem_valid_f` / `mem_valid_m`, the acknowledge signals the hazard unit consumes to stall fetch and memory stages. Stores are posted through a small write buffer so the memory stage never waits on a store unless the buffer is full.

## Interface
- `XLEN`, 32: address and data width.
- `WBUF_DEPTH`, 2: write-buffer entries, power of two, at least 1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `f_req`  in  1  fetch request; address held stable until `mem_valid_f`.
- `f_addr`  in  XLEN  fetch address.
- `f_rdata`  out  XLEN  fetched word.
- `mem_valid_f`  out  1  fetch response valid; one-cycle pulse.
- `m_req`  in  1  data request from memory stage.
- `m_we`  in  1  1 = store, 0 = load.
- `m_addr`  in  XLEN  data address.
- `m_wdata`  in  XLEN  store data.
- `m_be`  in  XLEN/8  store byte enables.
- `m_rdata`  out  XLEN  load word.
- `mem_valid_m`  out  1  data request accepted (store) or completed (load).
- `wbuf_empty`  out  1  write buffer empty; used for fence.
- `bus_req`  out  1  bus transaction request; held until `bus_ack`.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  1/XLEN/XLEN/XLEN/8  registered bus command.
- `bus_ack`  in  1  bus completion; `bus_rdata` valid in the same cycle.
- `bus_rdata`  in  XLEN  bus read data.

## Operation
- FSM states: IDLE, FETCH, LOAD, STORE. One outstanding bus transaction at a time.
- Arbitration in IDLE, highest first:
  - A non-empty write buffer goes to STORE.
  - `m_req && !m_we` with the buffer empty goes to LOAD.
  - `f_req` goes to FETCH.
- A load never bypasses buffered stores. It waits until the buffer is empty, so there is no address compare and no forwarding.
- Entering a state registers the bus command and asserts `bus_req`. `bus_addr` = request address with bits [1:0] forced to 0, and only whole words are returned. For reads, `bus_be` is all ones.
- On `bus_ack`:
  - `bus_req` drops.
  - FETCH/LOAD register `bus_rdata` into `f_rdata`/`m_rdata`. The data holds until the next response on that port.
  - STORE pops the buffer head.
  - The FSM returns to IDLE.
- Store acceptance:
  - `mem_valid_m = m_req && m_we && !full` combinationally in the same cycle, and the entry is pushed at that edge.
  - If the buffer is full, `mem_valid_m` stays 0 and the memory stage is held until space frees.
  - A push and a pop in the same cycle keep the count unchanged.
- Stale fetch: the fetch address is latched at issue. If `f_addr` differs from the latched address at `bus_ack` (redirect or flush), the response is discarded, `mem_valid_f` stays 0 and the fetch is reissued from IDLE.
- A repeated fetch of the same address after a pulse (pipeline stalled for another reason) is simply served again.

## Timing
- Reset values:
  - all `bus_*` outputs 0;
  - `mem_valid_f`/`mem_valid_m` 0;
  - `f_rdata`/`m_rdata` 0;
  - buffer empty and `wbuf_empty` 1;
  - FSM in IDLE.
- Reset mid-transaction abandons `bus_req` and discards buffered stores. The bus slave must tolerate this.
- A read request sampled in IDLE at edge N gives `bus_req` high after N. With `bus_ack` in the next cycle, `mem_valid_f`/`mem_valid_m` (load) pulses exactly one cycle after the ack cycle. Minimum read latency is 2 cycles.
- Load/fetch valid pulses are registered. Store valid is combinational.
- With `WBUF_DEPTH` stores pending and a zero-wait bus, each drain takes 2 cycles (issue, ack).
- `wbuf_empty` is registered from the count and drops the cycle after the first push.

## Structure
- Shared package: FSM state encoding, `XLEN` default, bus command struct (we/addr/wdata/be).
- Sub-module `store_buffer`: synchronous FIFO of {addr, wdata, be}, `WBUF_DEPTH` deep, with a pointer wrap-around counter and `full`/`empty` flags.
- Arbitration and the FSM stay in the top module.

## Test plan
- Fetch `f_addr=0x100`, bus acks one cycle after `bus_req` with `0x00000013` -> `bus_addr=0x100`, `mem_valid_f` one-cycle pulse 2 cycles after request, `f_rdata=0x00000013`.
- Store `0x200<=0xDEADBEEF`, `be=0xF`, then a load from `0x200` on the next cycle -> store valid the same cycle, load waits for the drain, `m_rdata=0xDEADBEEF`.
- Three back-to-back stores with a 4-cycle ack delay and `WBUF_DEPTH=2` -> first two accepted immediately, third sees `mem_valid_m=0` until the first ack, then is accepted.
- Fetch of `0x100` in flight, `f_addr` changes to `0x300` before the ack -> no pulse for `0x100`, new `bus_req` with `0x300`, pulse with `0x300` data.
- Fetch and load requested in the same IDLE cycle with the buffer empty -> LOAD issued first, fetch afterwards.
- `rst` asserted while `bus_req` is high with 2 stores buffered -> all outputs return to reset values asynchronously, `wbuf_empty=1`.
